// File: rtl/i_ddr_pkg.sv
// Shared types and constants for the i_ddr_deser input deserializer family.
package i_ddr_pkg;

  typedef enum logic {
    IDDR_SDR = 1'b0,
    IDDR_DDR = 1'b1
  } iddr_mode_t;

  localparam int IDDR_MAX_RATIO    = 10;
  localparam int IDDR_MAX_CHANNELS = 16;
  localparam int IDDR_CNT_W        = $clog2(IDDR_MAX_RATIO + 1);

  function automatic int unsigned bits_per_cycle(input iddr_mode_t mode);
    case (mode)
      IDDR_DDR: bits_per_cycle = 32'd2;
      IDDR_SDR: bits_per_cycle = 32'd1;
      default:  bits_per_cycle = 32'd1;
    endcase
  endfunction

endpackage

// File: rtl/i_ddr_deser_lane.sv
// One serial lane of i_ddr_deser: falling-edge half-bit capture (DDR), word shift
// register and the offset-selected word window. The parent picks the register width.
module i_ddr_deser_lane
  import i_ddr_pkg::*;
#(
  parameter int         RATIO = 4,
  parameter iddr_mode_t MODE  = IDDR_DDR,
  parameter int         SR_W  = 8,
  parameter int         OFF_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sample_i,
  input  logic             shift_i,
  input  logic             din_i,
  input  logic [OFF_W-1:0] offset_i,
  output logic [RATIO-1:0] win_o
);

  logic [SR_W-1:0] sr_q;
  logic [SR_W-1:0] sr_d;
  logic [SR_W-1:0] aligned_s;

  if (MODE == IDDR_DDR) begin : g_ddr
    logic            rise_q;
    logic            rise_d;
    logic            fall_q;
    logic [SR_W+1:0] ext_s;

    // Falling-edge sample: the newer bit of each pair
    always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
        fall_q <= 1'b0;
      end else begin
        fall_q <= din_i;
      end
    end

    // Rising-edge sample held until its pair is shifted in
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rise_q <= 1'b0;
      end else begin
        rise_q <= rise_d;
      end
    end

    // Pair insertion: rising bit is older, falling bit newest
    always_comb begin
      ext_s = {fall_q, rise_q, sr_q};
      if (sample_i) begin
        rise_d = din_i;
      end else begin
        rise_d = rise_q;
      end
      if (shift_i) begin
        sr_d = ext_s[SR_W+1:2];
      end else begin
        sr_d = sr_q;
      end
    end
  end else begin : g_sdr
    logic [SR_W:0] ext_s;
    logic          unused_sample_s;

    assign unused_sample_s = sample_i;

    // Single-bit insertion at the newest end
    always_comb begin
      ext_s = {din_i, sr_q};
      if (shift_i) begin
        sr_d = ext_s[SR_W:1];
      end else begin
        sr_d = sr_q;
      end
    end
  end

  // Shift register state; MSB holds the newest bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  // Window looks at the post-shift contents so a word is visible on the edge it completes
  always_comb begin
    aligned_s = sr_d >> ((SR_W - RATIO) - 32'(offset_i));
    win_o     = aligned_s[RATIO-1:0];
  end

endmodule

// File: rtl/i_ddr_deser.sv
// Multi-channel SDR/DDR input deserializer with one-cycle DV strobe per word.
// Optional word-alignment bitslip is enabled by defining I_DDR_DESER_BITSLIP_EN.
module i_ddr_deser
  import i_ddr_pkg::*;
#(
  parameter int CHANNELS = 1,
  parameter int RATIO    = 4,
  parameter int DDR_MODE = 1
) (
  input  logic                         C,
  input  logic                         R,
  input  logic                         E,
  input  logic [CHANNELS-1:0]          D,
  input  logic                         BITSLIP,
  output logic [CHANNELS*RATIO-1:0]    Q,
  output logic                         DV
);

  localparam iddr_mode_t MODE  = (DDR_MODE != 0) ? IDDR_DDR : IDDR_SDR;
  localparam int         BPC   = int'(bits_per_cycle(MODE));
  localparam int         OFF_W = (RATIO > 2) ? $clog2(RATIO) : 1;
`ifdef I_DDR_DESER_BITSLIP_EN
  localparam int         SR_W  = 2 * RATIO;
`else
  localparam int         SR_W  = RATIO;
`endif
  localparam logic [IDDR_CNT_W-1:0] CNT_STEP = IDDR_CNT_W'(BPC);
  localparam logic [IDDR_CNT_W-1:0] CNT_WORD = IDDR_CNT_W'(RATIO);

  if (CHANNELS < 1 || CHANNELS > IDDR_MAX_CHANNELS) begin : g_bad_channels
    $error("i_ddr_deser: CHANNELS must be in 1..16");
  end
  if (RATIO < 2 || RATIO > IDDR_MAX_RATIO) begin : g_bad_ratio
    $error("i_ddr_deser: RATIO must be in 2..10");
  end
  if (DDR_MODE != 0 && DDR_MODE != 1) begin : g_bad_mode
    $error("i_ddr_deser: DDR_MODE must be 0 or 1");
  end
  if (DDR_MODE == 1 && (RATIO % 2) != 0) begin : g_bad_odd
    $error("i_ddr_deser: RATIO must be even in DDR mode");
  end

  logic [IDDR_CNT_W-1:0]     cnt_q;
  logic [IDDR_CNT_W-1:0]     cnt_d;
  logic [IDDR_CNT_W-1:0]     cnt_next_s;
  logic                      pend_q;
  logic                      pend_d;
  logic                      advance_s;
  logic [CHANNELS*RATIO-1:0] q_q;
  logic [CHANNELS*RATIO-1:0] q_d;
  logic                      dv_q;
  logic                      dv_d;
  logic [OFF_W-1:0]          off_s;
  logic [CHANNELS*RATIO-1:0] win_all_s;

  // A DDR pair enters one edge after its rising bit was taken, even if E has since dropped
  assign advance_s  = (MODE == IDDR_DDR) ? pend_q : E;
  assign cnt_next_s = cnt_q + CNT_STEP;

`ifdef I_DDR_DESER_BITSLIP_EN
  localparam logic [OFF_W-1:0] OFF_MAX = OFF_W'(RATIO - 1);
  logic [OFF_W-1:0] off_q;
  logic [OFF_W-1:0] off_d;

  // Slip offset advance, wrapping modulo RATIO
  always_comb begin
    if (E && BITSLIP) begin
      if (off_q == OFF_MAX) begin
        off_d = '0;
      end else begin
        off_d = off_q + OFF_W'(1);
      end
    end else begin
      off_d = off_q;
    end
  end

  // Slip offset register; the completing word on a slip edge still sees the old value
  always_ff @(posedge C or negedge R) begin
    if (!R) begin
      off_q <= '0;
    end else begin
      off_q <= off_d;
    end
  end

  assign off_s = off_q;
`else
  logic unused_bitslip_s;

  assign unused_bitslip_s = BITSLIP;
  assign off_s            = '0;
`endif

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    i_ddr_deser_lane #(
      .RATIO (RATIO),
      .MODE  (MODE),
      .SR_W  (SR_W),
      .OFF_W (OFF_W)
    ) u_lane (
      .clk      (C),
      .rst_n    (R),
      .sample_i (E),
      .shift_i  (advance_s),
      .din_i    (D[c]),
      .offset_i (off_s),
      .win_o    (win_all_s[c*RATIO +: RATIO])
    );
  end

  // Bit counter, word completion and output capture
  always_comb begin
    pend_d = E;
    dv_d   = 1'b0;
    q_d    = q_q;
    cnt_d  = cnt_q;
    if (advance_s) begin
      if (cnt_next_s == CNT_WORD) begin
        cnt_d = '0;
        dv_d  = 1'b1;
        q_d   = win_all_s;
      end else begin
        cnt_d = cnt_next_s;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Control and output registers
  always_ff @(posedge C or negedge R) begin
    if (!R) begin
      cnt_q  <= '0;
      pend_q <= 1'b0;
      q_q    <= '0;
      dv_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
      q_q    <= q_d;
      dv_q   <= dv_d;
    end
  end

  assign Q  = q_q;
  assign DV = dv_q;

endmodule

// File: tb/tb_i_ddr_deser.sv
// Self-checking bench for i_ddr_deser: three instances (DDR 4x1, SDR 8x2, DDR 6x3)
// compared every cycle against a bit-stream reference model, plus directed sequences.
module tb_i_ddr_deser;

  localparam int NI = 3;
  localparam int RAT [NI] = '{4, 8, 6};
  localparam int CHN [NI] = '{1, 2, 3};
  localparam bit DDRM [NI] = '{1'b1, 1'b0, 1'b1};
`ifdef I_DDR_DESER_BITSLIP_EN
  localparam bit SLIP_EN = 1'b1;
`else
  localparam bit SLIP_EN = 1'b0;
`endif

  logic        C;
  logic        R;
  logic        E0, E1, E2;
  logic        B0, B1, B2;
  logic [0:0]  D0;
  logic [1:0]  D1;
  logic [2:0]  D2;
  logic [3:0]  Q0;
  logic [15:0] Q1;
  logic [17:0] Q2;
  logic        DV0, DV1, DV2;

  i_ddr_deser #(.CHANNELS(1), .RATIO(4), .DDR_MODE(1)) u0 (
    .C(C), .R(R), .E(E0), .D(D0), .BITSLIP(B0), .Q(Q0), .DV(DV0));
  i_ddr_deser #(.CHANNELS(2), .RATIO(8), .DDR_MODE(0)) u1 (
    .C(C), .R(R), .E(E1), .D(D1), .BITSLIP(B1), .Q(Q1), .DV(DV1));
  i_ddr_deser #(.CHANNELS(3), .RATIO(6), .DDR_MODE(1)) u2 (
    .C(C), .R(R), .E(E2), .D(D2), .BITSLIP(B2), .Q(Q2), .DV(DV2));

  always #5 C = ~C;

  // stimulus for the next cycle, per instance
  logic [2:0] in_r [NI];
  logic [2:0] in_f [NI];
  logic       in_e [NI];
  logic       in_s [NI];

  // reference model: accepted bit history per lane (index = inst*3 + lane)
  bit          hist [9][$];
  int          nbits [NI];
  int          off [NI];
  bit          pend [NI];
  logic [2:0]  pend_r [NI];
  logic [2:0]  prev_f [NI];
  logic [31:0] mq [NI];
  logic        mdv [NI];

  int n_chk;
  int n_fail;
  int cyc_n;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %h, expected %h", name, cyc_n, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      nbits[i]  = 0;
      off[i]    = 0;
      pend[i]   = 1'b0;
      pend_r[i] = 3'b000;
      mq[i]     = 32'd0;
      mdv[i]    = 1'b0;
      for (int l = 0; l < 3; l++) hist[i*3+l].delete();
    end
  endtask

  // Word = RATIO bits ending `off` bits before the newest accepted bit
  task automatic model_word(input int i);
    int idx;
    mdv[i] = 1'b1;
    mq[i]  = 32'd0;
    for (int l = 0; l < CHN[i]; l++) begin
      for (int j = 0; j < RAT[i]; j++) begin
        idx = nbits[i] - RAT[i] - off[i] + j;
        if (idx >= 0) mq[i][l*RAT[i]+j] = hist[i*3+l][idx];
      end
    end
  endtask

  task automatic model_edge(input int i);
    mdv[i] = 1'b0;
    if (DDRM[i]) begin
      if (pend[i]) begin
        for (int l = 0; l < CHN[i]; l++) begin
          hist[i*3+l].push_back(pend_r[i][l]);
          hist[i*3+l].push_back(prev_f[i][l]);
        end
        nbits[i] += 2;
        if (nbits[i] % RAT[i] == 0) model_word(i);
      end
      pend[i] = in_e[i];
      if (in_e[i]) pend_r[i] = in_r[i];
    end else if (in_e[i]) begin
      for (int l = 0; l < CHN[i]; l++) hist[i*3+l].push_back(in_r[i][l]);
      nbits[i] += 1;
      if (nbits[i] % RAT[i] == 0) model_word(i);
    end
    if (SLIP_EN && in_e[i] && in_s[i]) off[i] = (off[i] + 1) % RAT[i];
  endtask

  // One C cycle: called and returns just after a falling edge
  task automatic cyc();
    E0 = in_e[0]; B0 = in_s[0]; D0 = in_r[0][0:0];
    E1 = in_e[1]; B1 = in_s[1]; D1 = in_r[1][1:0];
    E2 = in_e[2]; B2 = in_s[2]; D2 = in_r[2];
    @(posedge C);
    if (R) begin
      for (int i = 0; i < NI; i++) model_edge(i);
    end else begin
      model_reset();
    end
    #1;
    cyc_n++;
    chk("u0.dv", 32'(DV0), 32'(mdv[0]));
    chk("u0.q",  32'(Q0),  mq[0]);
    chk("u1.dv", 32'(DV1), 32'(mdv[1]));
    chk("u1.q",  32'(Q1),  mq[1]);
    chk("u2.dv", 32'(DV2), 32'(mdv[2]));
    chk("u2.q",  32'(Q2),  mq[2]);
    D0 = in_f[0][0:0];
    D1 = in_f[1][1:0];
    D2 = in_f[2];
    for (int i = 0; i < NI; i++) prev_f[i] = in_f[i];
    @(negedge C);
    #1;
  endtask

  // Asynchronous reset pulse between clock edges; outputs must clear at once
  task automatic pulse_rst();
    R = 1'b0;
    #1;
    model_reset();
    chk("rst_async.q0", 32'(Q0), 32'd0);
    chk("rst_async.dv0", 32'(DV0), 32'd0);
    chk("rst_async.q1", 32'(Q1), 32'd0);
    chk("rst_async.q2", 32'(Q2), 32'd0);
    #1;
    R = 1'b1;
  endtask

  task automatic idle_all();
    for (int i = 0; i < NI; i++) begin
      in_e[i] = 1'b0; in_s[i] = 1'b0; in_r[i] = 3'b000; in_f[i] = 3'b000;
    end
  endtask

  typedef struct {
    bit         pre_rst;
    bit         e;
    bit         r;
    bit         f;
    bit         exp_dv;
    logic [3:0] exp_q;
  } vec_t;

  vec_t tbl [15];
  int   dv_cnt;

  initial begin
    logic [7:0] l0;
    logic [7:0] l1;
    logic [3:0] exp_q;

    // DDR RATIO=4 pair sequence, then E held low for 3 cycles mid-word
    tbl[0]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000};
    tbl[1]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000};
    tbl[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'b1101};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b1101};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b1001};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1001};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0000};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'b1001};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b1001};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b1001};
    tbl[12] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b1001};
    tbl[13] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b1001};
    tbl[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0111};

    C = 1'b0; R = 1'b0;
    n_chk = 0; n_fail = 0; cyc_n = 0; dv_cnt = 0;
    idle_all();
    model_reset();
    for (int i = 0; i < NI; i++) prev_f[i] = 3'b000;
    #1;

    // reset held with toggling data and enable
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < NI; i++) begin
        in_e[i] = 1'b1; in_r[i] = 3'($urandom); in_f[i] = 3'($urandom);
      end
      cyc();
      chk("rst_hold.q0", 32'(Q0), 32'd0);
      chk("rst_hold.dv1", 32'(DV1), 32'd0);
    end
    idle_all();
    #1;
    R = 1'b1;

    for (int k = 0; k < 15; k++) begin
      if (tbl[k].pre_rst) pulse_rst();
      in_e[0] = tbl[k].e;
      in_r[0] = {2'b00, tbl[k].r};
      in_f[0] = {2'b00, tbl[k].f};
      cyc();
      chk("tbl.dv", 32'(DV0), 32'(tbl[k].exp_dv));
      chk("tbl.q",  32'(Q0),  32'(tbl[k].exp_q));
    end
    idle_all();

    // SDR 8x2: lane0 0xA5, lane1 0x3C, LSB first, two words
    l0 = 8'hA5;
    l1 = 8'h3C;
    for (int k = 0; k < 16; k++) begin
      in_e[1] = 1'b1;
      in_r[1] = {1'b0, l1[k%8], l0[k%8]};
      in_f[1] = 3'($urandom);
      cyc();
      if (DV1) dv_cnt++;
      if (k == 7 || k == 15) begin
        chk("sdr.word", 32'(Q1), 32'h3CA5);
        chk("sdr.dv",   32'(DV1), 32'd1);
      end
    end
    chk("sdr.dv_count", 32'(dv_cnt), 32'd2);
    idle_all();

    // repeating 0001 with slips at cycles 8, 10, 11, 12
    pulse_rst();
    for (int k = 1; k <= 13; k++) begin
      in_e[0] = 1'b1;
      in_r[0] = {2'b00, (k % 2 == 1)};
      in_f[0] = 3'b000;
      in_s[0] = (k == 8 || k == 10 || k == 11 || k == 12);
      cyc();
      if (k == 3) chk("slip.aligned", 32'(Q0), 32'h1);
      if (k == 9) begin
        exp_q = SLIP_EN ? 4'b0010 : 4'b0001;
        chk("slip.one", 32'(Q0), 32'(exp_q));
      end
      if (k == 11) begin
        exp_q = SLIP_EN ? 4'b0100 : 4'b0001;
        chk("slip.same_edge", 32'(Q0), 32'(exp_q));
      end
      if (k == 13) chk("slip.four", 32'(Q0), 32'h1);
      if (k >= 9 && k % 2 == 1) chk("slip.dv_on", 32'(DV0), 32'd1);
      if (k >= 9 && k % 2 == 0) chk("slip.dv_off", 32'(DV0), 32'd0);
    end
    idle_all();

    // two slips, then reset right after a completed word
    pulse_rst();
    for (int k = 1; k <= 9; k++) begin
      in_e[0] = 1'b1;
      in_r[0] = {2'b00, (k % 2 == 1)};
      in_s[0] = (k == 4 || k == 6);
      cyc();
    end
    exp_q = SLIP_EN ? 4'b0100 : 4'b0001;
    chk("slip2.q", 32'(Q0), 32'(exp_q));
    chk("slip2.dv_high", 32'(DV0), 32'd1);
    pulse_rst();
    for (int k = 1; k <= 3; k++) begin
      in_e[0] = 1'b1;
      in_r[0] = {2'b00, (k % 2 == 1)};
      in_s[0] = 1'b0;
      cyc();
    end
    chk("slip2.offset_cleared", 32'(Q0), 32'h1);
    chk("slip2.first_dv", 32'(DV0), 32'd1);
    idle_all();

    // randomized traffic on all instances
    for (int n = 0; n < 400; n++) begin
      if (n == 200) pulse_rst();
      for (int i = 0; i < NI; i++) begin
        in_e[i] = ($urandom_range(7, 0) != 0);
        in_s[i] = ($urandom_range(15, 0) == 0);
        in_r[i] = 3'($urandom);
        in_f[i] = 3'($urandom);
      end
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
